// File: rtl/exec_stage_mc.sv
// exec_stage_mc: execute stage between decode and memory access.
//
// Resolves rs1/rs2 through an operand forwarding network (own result first,
// then external sources in index order, then register-file data), selects the
// ALU operands, and runs three kinds of operation:
//   ALU     single cycle, result taken from the external combinational ALU
//   MULDIV  iterative unsigned mul/mulhu/divu/remu, one bit per cycle
//   EXT     start/done handshake to an external long-latency unit
// Multi-cycle operations hold every pipeline register and raise wait_out.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   stall, flush                      bubble request / kill in-flight op
//   ctl, op_class                     operation code and class
//   src_pc, src_imm, imm, pc_in       operand A/B select and sources
//   rs1_*/rs2_*                       source addresses, FP flags, read data
//   rd_in .. mem_read_in              destination and control fields
//   fwd_we/fwd_f/fwd_addr/fwd_data    external forwarding sources
//   alu_a, alu_b, alu_y               external ALU operands and result
//   ext_start/ext_ctl/ext_a/ext_b     external unit request
//   ext_done/ext_result               external unit response
//   rd_out .. mem_read_out, pc_out,
//   mem_wdata, result                 registered stage outputs
//   wait_out                          multi-cycle op in progress

module exec_stage_mc #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int NFWD    = 2,
    parameter int CTL_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [CTL_W-1:0]        ctl,
    input  logic [1:0]              op_class,
    input  logic                    src_pc,
    input  logic                    src_imm,
    input  logic [XLEN-1:0]         imm,
    input  logic [XLEN-1:0]         pc_in,
    input  logic [RADDR_W-1:0]      rs1_addr,
    input  logic [RADDR_W-1:0]      rs2_addr,
    input  logic                    rs1_f,
    input  logic                    rs2_f,
    input  logic [XLEN-1:0]         rs1_data,
    input  logic [XLEN-1:0]         rs2_data,
    input  logic [RADDR_W-1:0]      rd_in,
    input  logic                    rdf_in,
    input  logic                    reg_write_in,
    input  logic                    mem_write_in,
    input  logic                    mem_read_in,
    input  logic [NFWD-1:0]         fwd_we,
    input  logic [NFWD-1:0]         fwd_f,
    input  logic [NFWD*RADDR_W-1:0] fwd_addr,
    input  logic [NFWD*XLEN-1:0]    fwd_data,
    output logic [XLEN-1:0]         alu_a,
    output logic [XLEN-1:0]         alu_b,
    input  logic [XLEN-1:0]         alu_y,
    output logic                    ext_start,
    output logic [CTL_W-1:0]        ext_ctl,
    output logic [XLEN-1:0]         ext_a,
    output logic [XLEN-1:0]         ext_b,
    input  logic                    ext_done,
    input  logic [XLEN-1:0]         ext_result,
    output logic [RADDR_W-1:0]      rd_out,
    output logic                    rdf_out,
    output logic                    reg_write_out,
    output logic                    mem_write_out,
    output logic                    mem_read_out,
    output logic [XLEN-1:0]         pc_out,
    output logic [XLEN-1:0]         mem_wdata,
    output logic [XLEN-1:0]         result,
    output logic                    wait_out
);

    localparam int         CNT_W      = $clog2(XLEN + 1);
    localparam logic [1:0] CLS_MULDIV = 2'd1;
    localparam logic [1:0] CLS_EXT    = 2'd2;

    logic [CNT_W-1:0]  cnt;
    logic              ext_pending;
    logic [2*XLEN-1:0] md_acc;
    logic [XLEN-1:0]   md_b;
    logic [1:0]        md_op;

    logic [XLEN-1:0]   fwd1, fwd2;
    logic              accept;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next, md_next;
    logic [XLEN-1:0]   rem_sh, div_hi;
    logic              div_ge;

    // Lowest index is applied last so it wins; own result overrides all
    // external sources, and integer x0 always reads as zero.
    function automatic logic [XLEN-1:0] resolve(input logic [RADDR_W-1:0] addr,
                                                 input logic f,
                                                 input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] v;
        v = rdata;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_addr[i*RADDR_W +: RADDR_W] == addr && fwd_f[i] == f)
                v = fwd_data[i*XLEN +: XLEN];
        end
        if (reg_write_out && rd_out == addr && rdf_out == f)
            v = result;
        if (addr == '0 && !f)
            v = '0;
        return v;
    endfunction

    assign fwd1 = resolve(rs1_addr, rs1_f, rs1_data);
    assign fwd2 = resolve(rs2_addr, rs2_f, rs2_data);

    assign alu_a = src_pc  ? pc_in : fwd1;
    assign alu_b = src_imm ? imm   : fwd2;

    assign wait_out  = (cnt != '0) || ext_pending;
    assign accept    = !wait_out && !stall && !flush;
    assign ext_start = accept && (op_class == CLS_EXT);
    assign ext_ctl   = ctl;
    assign ext_a     = fwd1;
    assign ext_b     = fwd2;

    // One iteration of the shared accumulator. Multiply: add multiplicand to
    // the upper half when the LSB is set, then shift right. Divide: shift left,
    // trial-subtract the divisor; the bit shifted out of the top means the
    // partial remainder already exceeds any XLEN-bit divisor, and the modular
    // subtraction still yields the correct low XLEN bits.
    always_comb begin
        mul_sum  = {1'b0, md_acc[2*XLEN-1:XLEN]} + (md_acc[0] ? {1'b0, md_b} : '0);
        mul_next = {mul_sum, md_acc[XLEN-1:1]};
        rem_sh   = md_acc[2*XLEN-2:XLEN-1];
        div_ge   = md_acc[2*XLEN-1] || (rem_sh >= md_b);
        div_hi   = div_ge ? (rem_sh - md_b) : rem_sh;
        div_next = {div_hi, md_acc[XLEN-2:0], div_ge};
        md_next  = md_op[1] ? div_next : mul_next;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_out        <= '0;
            rdf_out       <= 1'b0;
            reg_write_out <= 1'b0;
            mem_write_out <= 1'b0;
            mem_read_out  <= 1'b0;
            pc_out        <= '0;
            mem_wdata     <= '0;
            result        <= '0;
            cnt           <= '0;
            ext_pending   <= 1'b0;
            if (rst) begin
                md_acc <= '0;
                md_b   <= '0;
                md_op  <= '0;
            end
        end else if (wait_out) begin
            if (cnt != '0) begin
                cnt    <= cnt - CNT_W'(1);
                md_acc <= md_next;
                // mul/divu keep their answer in the low half, mulhu/remu high
                if (cnt == CNT_W'(1))
                    result <= md_op[0] ? md_next[2*XLEN-1:XLEN] : md_next[XLEN-1:0];
            end
            if (ext_pending && ext_done) begin
                result      <= ext_result;
                ext_pending <= 1'b0;
            end
        end else if (stall) begin
            rd_out        <= '0;
            rdf_out       <= 1'b0;
            reg_write_out <= 1'b0;
            mem_write_out <= 1'b0;
            mem_read_out  <= 1'b0;
            pc_out        <= '0;
            mem_wdata     <= '0;
            result        <= '0;
        end else begin
            rd_out        <= rd_in;
            rdf_out       <= rdf_in;
            reg_write_out <= reg_write_in;
            mem_write_out <= mem_write_in;
            mem_read_out  <= mem_read_in;
            pc_out        <= pc_in;
            mem_wdata     <= fwd2;
            case (op_class)
                CLS_MULDIV: begin
                    md_acc <= {{XLEN{1'b0}}, fwd1};
                    md_b   <= fwd2;
                    md_op  <= ctl[1:0];
                    cnt    <= CNT_W'(XLEN);
                end
                CLS_EXT: ext_pending <= 1'b1;
                default: result <= alu_y;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_stage_mc.sv
module tb_exec_stage_mc;

    localparam int XLEN = 32, RADDR_W = 5, NFWD = 2, CTL_W = 5;

    logic clk = 1'b0, rst, stall, flush;
    logic [CTL_W-1:0] ctl;
    logic [1:0] op_class;
    logic src_pc, src_imm;
    logic [XLEN-1:0] imm, pc_in, rs1_data, rs2_data;
    logic [RADDR_W-1:0] rs1_addr, rs2_addr, rd_in;
    logic rs1_f, rs2_f, rdf_in, reg_write_in, mem_write_in, mem_read_in;
    logic [NFWD-1:0] fwd_we, fwd_f;
    logic [NFWD*RADDR_W-1:0] fwd_addr;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic [XLEN-1:0] alu_a, alu_b, alu_y;
    logic ext_start, ext_done;
    logic [CTL_W-1:0] ext_ctl;
    logic [XLEN-1:0] ext_a, ext_b, ext_result;
    logic [RADDR_W-1:0] rd_out;
    logic rdf_out, reg_write_out, mem_write_out, mem_read_out, wait_out;
    logic [XLEN-1:0] pc_out, mem_wdata, result;

    // stand-in for the external ADD-only ALU
    assign alu_y = alu_a + alu_b;

    always #5 clk = ~clk;

    exec_stage_mc #(.XLEN(XLEN), .RADDR_W(RADDR_W), .NFWD(NFWD), .CTL_W(CTL_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ctl(ctl), .op_class(op_class),
        .src_pc(src_pc), .src_imm(src_imm), .imm(imm), .pc_in(pc_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_f(rs1_f), .rs2_f(rs2_f),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .rdf_in(rdf_in),
        .reg_write_in(reg_write_in), .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
        .fwd_we(fwd_we), .fwd_f(fwd_f), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .ext_start(ext_start), .ext_ctl(ext_ctl), .ext_a(ext_a), .ext_b(ext_b),
        .ext_done(ext_done), .ext_result(ext_result),
        .rd_out(rd_out), .rdf_out(rdf_out), .reg_write_out(reg_write_out),
        .mem_write_out(mem_write_out), .mem_read_out(mem_read_out),
        .pc_out(pc_out), .mem_wdata(mem_wdata), .result(result), .wait_out(wait_out)
    );

    int n_checks = 0, n_pass = 0, n_fail = 0;
    logic [XLEN-1:0] sb_q[$];
    string sb_tag[$];

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [XLEN-1:0] exp);
        sb_q.push_back(exp);
        sb_tag.push_back(tag);
    endtask

    task automatic sb_check();
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL sb_underflow: observed result 0x%08h expected none pending", result);
        end else begin
            chk(sb_tag.pop_front(), result, sb_q.pop_front());
        end
    endtask

    function automatic logic [XLEN-1:0] md_model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        case (op)
            2'd0:    return p[XLEN-1:0];
            2'd1:    return p[2*XLEN-1:XLEN];
            2'd2:    return (b == '0) ? '1 : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    task automatic idle();
        stall = 0; flush = 0; ctl = '0; op_class = '0; src_pc = 0; src_imm = 0;
        imm = '0; pc_in = '0; rs1_addr = '0; rs2_addr = '0; rs1_f = 0; rs2_f = 0;
        rs1_data = '0; rs2_data = '0; rd_in = '0; rdf_in = 0; reg_write_in = 0;
        mem_write_in = 0; mem_read_in = 0; fwd_we = '0; fwd_f = '0; fwd_addr = '0;
        fwd_data = '0; ext_done = 0; ext_result = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ALU op with inputs already driven: check operand A, then the result
    task automatic do_alu(input string tag, input logic [XLEN-1:0] exp_a);
        @(negedge clk);
        chk({tag, "_alu_a"}, alu_a, exp_a);
        sb_push(tag, exp_a + (src_imm ? imm : rs2_data));
        step();
        sb_check();
    endtask

    task automatic run_md(input string tag, input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input logic stall_busy);
        int n;
        idle();
        op_class = 2'd1; ctl = {3'b0, op};
        rs1_addr = 5'd20; rs1_data = a; rs2_addr = 5'd21; rs2_data = b;
        rd_in = 5'd3; reg_write_in = 1;
        sb_push(tag, exp);
        step();
        idle();
        stall = stall_busy;
        n = 0;
        while (wait_out && n < 100) begin
            n++;
            step();
        end
        stall = 0;
        chk({tag, "_wait_cycles"}, n, 32);
        sb_check();
        chk({tag, "_rd_out"}, rd_out, 3);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish expected finish before 300000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, starts;
        logic [XLEN-1:0] ra, rb;
        idle();
        rst = 1;
        step(); step();
        chk("rst_result", result, 0);
        chk("rst_wait", wait_out, 0);
        chk("rst_rd_out", rd_out, 0);
        chk("rst_pc_out", pc_out, 0);
        rst = 0;

        // forwarding priority
        src_imm = 1; imm = 32'h11; rd_in = 5'd5; reg_write_in = 1; pc_in = 32'h100;
        rs2_addr = 5'd9; rs2_data = 32'h99; mem_write_in = 1;
        do_alu("op_x0_src", 0);
        chk("fields_rd_out", rd_out, 5);
        chk("fields_pc_out", pc_out, 32'h100);
        chk("fields_mem_wdata", mem_wdata, 32'h99);
        chk("fields_mem_write", mem_write_out, 1);
        imm = 0; rd_in = 5'd6; rs1_addr = 5'd5; rs1_data = 32'h33;
        fwd_we = 2'b11; fwd_addr = {5'd5, 5'd5}; fwd_data = {32'h44, 32'h22};
        do_alu("fwd_own", 32'h11);
        rd_in = 5'd7;
        do_alu("fwd_p0", 32'h22);
        fwd_we = 2'b10;
        do_alu("fwd_p1", 32'h44);
        fwd_we = 2'b00;
        do_alu("fwd_rf", 32'h33);
        rs1_addr = 5'd0; fwd_we = 2'b01; fwd_addr = '0; fwd_data = {32'h0, 32'h66};
        do_alu("fwd_x0_zero", 0);
        rs1_f = 1; fwd_f = 2'b01; fwd_data = {32'h0, 32'h55};
        do_alu("fwd_x0_fp", 32'h55);
        idle();
        src_pc = 1; src_imm = 1; pc_in = 32'h200; rd_in = 5'd7; reg_write_in = 1;
        do_alu("src_pc", 32'h200);
        idle();
        src_imm = 1; rs2_addr = 5'd7; rs2_data = 32'hAAAA;
        do_alu("fwd2_own_op", 0);
        chk("fwd2_own_mem_wdata", mem_wdata, 32'h200);

        // multiply / divide
        run_md("mulhu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_md("mul_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_md("divu_100_7", 2'd2, 32'd100, 32'd7, 32'd14, 1);
        run_md("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 0);
        run_md("divu_by0", 2'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_md("remu_by0", 2'd3, 32'd5, 32'd0, 32'd5, 0);
        for (int k = 0; k < 8; k++) begin
            ra = $urandom;
            rb = (k < 4) ? $urandom : $urandom_range(1, 1000);
            run_md($sformatf("md_rand%0d", k), 2'(k), ra, rb, md_model(2'(k), ra, rb), 0);
        end

        // external unit handshake
        idle();
        op_class = 2'd2; ctl = 5'h0A; rs1_addr = 5'd20; rs1_data = 32'h1234;
        rs2_addr = 5'd21; rs2_data = 32'h5678; rd_in = 5'd4; reg_write_in = 1;
        @(negedge clk);
        chk("ext_start_accept", ext_start, 1);
        chk("ext_a", ext_a, 32'h1234);
        chk("ext_b", ext_b, 32'h5678);
        chk("ext_ctl", ext_ctl, 32'h0A);
        sb_push("ext_result", 32'hDEAD_BEEF);
        step();
        idle();
        n = 0; starts = 0;
        while (wait_out && n < 100) begin
            n++;
            if (ext_start) starts++;
            if (n == 5) begin ext_done = 1; ext_result = 32'hDEAD_BEEF; end
            step();
        end
        ext_done = 0;
        chk("ext_wait_cycles", n, 5);
        chk("ext_start_repeat", starts, 0);
        sb_check();

        // spurious ext_done while idle
        idle();
        src_imm = 1; imm = 32'h1234; ext_done = 1; ext_result = 32'hBAD0_BAD0;
        do_alu("spurious_done", 0);
        chk("spurious_wait", wait_out, 0);

        // stall while idle bubbles the stage
        idle();
        stall = 1; op_class = 2'd2; rd_in = 5'd5; reg_write_in = 1; pc_in = 32'h400;
        @(negedge clk);
        chk("stall_no_start", ext_start, 0);
        step();
        chk("stall_result", result, 0);
        chk("stall_rd_out", rd_out, 0);
        chk("stall_reg_write", reg_write_out, 0);
        chk("stall_pc_out", pc_out, 0);
        chk("stall_wait", wait_out, 0);

        // flush during divide
        idle();
        op_class = 2'd1; ctl = 5'd2; rs1_addr = 5'd20; rs1_data = 32'd100;
        rs2_addr = 5'd21; rs2_data = 32'd7; rd_in = 5'd3; reg_write_in = 1; pc_in = 32'h300;
        step();
        idle();
        repeat (9) step();
        chk("flush_busy_c10", wait_out, 1);
        flush = 1;
        step();
        flush = 0;
        chk("flush_wait", wait_out, 0);
        chk("flush_result", result, 0);
        chk("flush_rd_out", rd_out, 0);
        chk("flush_pc_out", pc_out, 0);

        // flush during external op, late ext_done ignored
        idle();
        op_class = 2'd2; rd_in = 5'd4; reg_write_in = 1;
        step();
        idle();
        step();
        flush = 1;
        step();
        flush = 0;
        chk("ext_flush_wait", wait_out, 0);
        src_imm = 1; imm = 32'h777; ext_done = 1; ext_result = 32'hDEAD_BEEF;
        do_alu("ext_flush_late_done", 0);
        chk("ext_flush_late_wait", wait_out, 0);

        // reset in the middle of a multiply
        idle();
        op_class = 2'd1; ctl = 5'd0; rs1_addr = 5'd20; rs1_data = 32'd9;
        rs2_addr = 5'd21; rs2_data = 32'd9; rd_in = 5'd3; reg_write_in = 1; pc_in = 32'h500;
        step();
        idle();
        repeat (5) step();
        rst = 1;
        step();
        chk("rst_mid_wait", wait_out, 0);
        chk("rst_mid_result", result, 0);
        chk("rst_mid_rd_out", rd_out, 0);
        chk("rst_mid_pc_out", pc_out, 0);
        chk("rst_mid_mem_wdata", mem_wdata, 0);
        rst = 0;
        step();
        chk("rst_mid_wait_after", wait_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
